uart_tx_frame: RTL and testbench

Parametrised, double-buffered UART transmitter; successor to the fixed 8N1 transmitter.
- Configurable data width, parity mode and stop-bit count.
- One-deep holding register, so the driver can queue the next byte while the current frame shifts out, giving gap-free back-to-back frames.
- Bit timing comes from an external one-cycle baud tick supplied by the shared baud divider.
- Sits between the byte-producing driver logic and the serial pin.

---
 rtl/uart_tx_frame_pkg.sv | 21 ++
 rtl/uart_tx_frame_if.sv | 23 ++
 rtl/uart_tx_hold_reg.sv | 29 ++
 rtl/uart_tx_frame.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_frame_pkg.sv
// rtl/uart_tx_frame_pkg.sv - shared types, parity constants and frame-length helper for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Number of baud ticks a frame occupies, counted from the tick that leaves IDLE.
    function automatic int frame_len(input int data_bits, input int parity_mode, input int stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - driver-side load handshake between byte producer and transmitter
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 xmit_go;
    logic                 tx_empty;
    logic                 tx_busy;

    modport master (
        output tx_data,
        output xmit_go,
        input  tx_empty,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  xmit_go,
        output tx_empty,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_hold_reg.sv
// rtl/uart_tx_hold_reg.sv - one-deep holding register with load handshake and empty flag
module uart_tx_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             take,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    // Capture only while empty so a queued byte is never overwritten; the
    // shifter's take frees the slot. take and an accepted load cannot coincide
    // because take only happens while the register is full.
    always_ff @(posedge clock) begin
        if (reset) begin
            empty <= 1'b1;
            data  <= '0;
        end else if (load && empty) begin
            data  <= load_data;
            empty <= 1'b0;
        end else if (take) begin
            empty <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised double-buffered UART transmitter; optional break via UART_TX_BREAK_EN
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  baud_tick,
`ifdef UART_TX_BREAK_EN
    input  logic                  tx_break,
`endif
    uart_tx_frame_if.slave        bus,
    output logic                  tx_out
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD_FLIP  = (PARITY_MODE == PAR_ODD);

    logic                 hold_empty;
    logic [DATA_BITS-1:0] hold_data;
    logic                 take;

    tx_state_t            state, state_next;
    logic [DATA_BITS-1:0] shifter, shifter_next;
    logic [3:0]           bit_cnt, bit_cnt_next;
    logic                 stop_cnt, stop_cnt_next;
    logic                 parity_bit, parity_next;
    logic                 line, line_next;
    logic                 busy, busy_next;
    logic                 start_frame;
`ifdef UART_TX_BREAK_EN
    logic                 brk_active, brk_next;
`endif

    uart_tx_hold_reg #(
        .WIDTH(DATA_BITS)
    ) u_hold (
        .clock     (clock),
        .reset     (reset),
        .load      (bus.xmit_go),
        .load_data (bus.tx_data),
        .take      (take),
        .empty     (hold_empty),
        .data      (hold_data)
    );

    assign bus.tx_empty = hold_empty;
    assign bus.tx_busy  = busy;
    assign tx_out       = line;

    // Frame state and line register; everything visible on the pin is registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            shifter    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            line       <= 1'b1;
            busy       <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_active <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shifter    <= shifter_next;
            bit_cnt    <= bit_cnt_next;
            stop_cnt   <= stop_cnt_next;
            parity_bit <= parity_next;
            line       <= line_next;
            busy       <= busy_next;
`ifdef UART_TX_BREAK_EN
            brk_active <= brk_next;
`endif
        end
    end

    // Next-state logic: the state names the bit being driven, and it only moves on baud ticks.
    always_comb begin
        state_next    = state;
        shifter_next  = shifter;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        parity_next   = parity_bit;
        line_next     = line;
        take          = 1'b0;
        start_frame   = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_next      = 1'b0;
        if (tx_break) begin
            // Hold the line low and freeze; the holding register is untouched.
            line_next = 1'b0;
            brk_next  = 1'b1;
        end else if (brk_active) begin
            // Leaving break abandons whatever frame was in flight.
            state_next    = IDLE;
            line_next     = 1'b1;
            bit_cnt_next  = '0;
            stop_cnt_next = 1'b0;
        end else
`endif
        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (!hold_empty) begin
                        start_frame = 1'b1;
                    end
                end
                START: begin
                    line_next    = shifter[0];
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_MODE != PAR_NONE) begin
                            line_next  = parity_bit;
                            state_next = PARITY;
                        end else begin
                            line_next     = 1'b1;
                            stop_cnt_next = 1'b0;
                            state_next    = STOP;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                        shifter_next = shifter >> 1;
                        line_next    = shifter[1];
                    end
                end
                PARITY: begin
                    line_next     = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = STOP;
                end
                STOP: begin
                    if (stop_cnt == LAST_STOP) begin
                        if (!hold_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            line_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
                default: begin
                    line_next  = 1'b1;
                    state_next = IDLE;
                end
            endcase

            // Shared by IDLE and the last stop bit so back-to-back frames have no gap.
            if (start_frame) begin
                take         = 1'b1;
                shifter_next = hold_data;
                parity_next  = (^hold_data) ^ ODD_FLIP;
                line_next    = 1'b0;
                state_next   = START;
            end
        end
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame; break scenario when UART_TX_BREAK_EN is defined
module tb_uart_tx_frame;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         start;
    } rx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b0;
    logic brk = 1'b0;
    logic m_out, e_out, o_out;

    int total = 0;
    int bad = 0;
    int tcnt = 0;
    int tick_idx = 0;

    logic [7:0] exp_q[$];
    rx_t        rx_q[$];

    int         mon_st = 0;
    int         mon_n = 0;
    logic [7:0] mon_sh;
    int         mon_start = 0;

    logic [31:0] rec_m, rec_e, rec_o, rec_bm, rec_be;

    uart_tx_frame_if #(.DATA_BITS(8)) m_if();
    uart_tx_frame_if #(.DATA_BITS(8)) e_if();
    uart_tx_frame_if #(.DATA_BITS(8)) o_if();

    uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut (
        .clock     (clk),
        .reset     (rst),
        .baud_tick (baud_tick),
`ifdef UART_TX_BREAK_EN
        .tx_break  (brk),
`endif
        .bus       (m_if.slave),
        .tx_out    (m_out)
    );

    uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_even (
        .clock     (clk),
        .reset     (rst),
        .baud_tick (baud_tick),
`ifdef UART_TX_BREAK_EN
        .tx_break  (1'b0),
`endif
        .bus       (e_if.slave),
        .tx_out    (e_out)
    );

    uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_odd (
        .clock     (clk),
        .reset     (rst),
        .baud_tick (baud_tick),
`ifdef UART_TX_BREAK_EN
        .tx_break  (1'b0),
`endif
        .bus       (o_if.slave),
        .tx_out    (o_out)
    );

    always #5 clk = ~clk;

    // One baud tick every 4 clocks, changed on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1) % 4;
            baud_tick = (tcnt == 0);
        end
    end

    // Line receiver for the 8N1 instance: decodes frames into rx_q.
    always @(posedge clk) begin
        if (rst || brk) begin
            mon_st = 0;
        end else if (baud_tick) begin
            #1;
            tick_idx = tick_idx + 1;
            case (mon_st)
                0: if (m_out === 1'b0) begin
                    mon_st = 1;
                    mon_n = 0;
                    mon_sh = 8'h00;
                    mon_start = tick_idx;
                end
                1: begin
                    mon_sh[mon_n] = m_out;
                    mon_n = mon_n + 1;
                    if (mon_n == 8) mon_st = 2;
                end
                default: begin
                    rx_q.push_back('{data: mon_sh, stop: m_out, start: mon_start});
                    mon_st = 0;
                end
            endcase
        end
    end

    function automatic logic [9:0] frame8(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic wait_tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
        #1;
    endtask

    task automatic record(input int n);
        rec_m = '0; rec_e = '0; rec_o = '0; rec_bm = '0; rec_be = '0;
        for (int i = 0; i < n; i++) begin
            wait_tick();
            rec_m[i]  = m_out;
            rec_e[i]  = e_out;
            rec_o[i]  = o_out;
            rec_bm[i] = m_if.tx_busy;
            rec_be[i] = e_if.tx_busy;
        end
    endtask

    task automatic load(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (m_if.tx_empty !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (m_if.tx_empty !== 1'b1) begin
            total++; bad++;
            $display("FAIL load_wait: tx_empty=%b required 1", m_if.tx_empty);
        end
        m_if.tx_data = d;
        m_if.xmit_go = 1'b1;
        exp_q.push_back(d);
        @(posedge clk);
        #1;
        m_if.xmit_go = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (rx_q.size() < n) begin
            bad++;
            $display("FAIL frame_wait: got %0d frames required %0d", rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++; if (m_out !== 1'b1) begin bad++; $display("FAIL reset_tx_out: got %b required 1", m_out); end
        total++; if (m_if.tx_empty !== 1'b1) begin bad++; $display("FAIL reset_tx_empty: got %b required 1", m_if.tx_empty); end
        total++; if (m_if.tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy: got %b required 0", m_if.tx_busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        rx_t r;
        logic [7:0] want;
        load(8'h55);
        record(12);
        total++; if (rec_m[11:0] !== {2'b11, frame8(8'h55)}) begin bad++; $display("FAIL single_line: got %b required %b", rec_m[11:0], {2'b11, frame8(8'h55)}); end
        total++; if (rec_bm[11:0] !== 12'b0011_1111_1111) begin bad++; $display("FAIL single_busy: got %b required %b", rec_bm[11:0], 12'b0011_1111_1111); end
        wait_frames(1);
        while (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (r.data !== want || r.stop !== 1'b1) begin bad++; $display("FAIL single_data: got %h stop %b required %h stop 1", r.data, r.stop, want); end
        end
    endtask

    task automatic test_parity();
        logic [12:0] want_e, want_o;
        @(negedge clk);
        e_if.tx_data = 8'h07; e_if.xmit_go = 1'b1;
        o_if.tx_data = 8'h07; o_if.xmit_go = 1'b1;
        @(posedge clk); #1;
        e_if.xmit_go = 1'b0; o_if.xmit_go = 1'b0;
        record(13);
        want_e = {2'b11, 1'b1, 1'b1, 8'h07, 1'b0};
        want_o = {2'b11, 1'b1, 1'b0, 8'h07, 1'b0};
        total++; if (rec_e[12:0] !== want_e) begin bad++; $display("FAIL even_line: got %b required %b", rec_e[12:0], want_e); end
        total++; if (rec_o[12:0] !== want_o) begin bad++; $display("FAIL odd_line: got %b required %b", rec_o[12:0], want_o); end
        total++; if (rec_be[12:0] !== 13'b0_0111_1111_1111) begin bad++; $display("FAIL parity_busy: got %b required %b", rec_be[12:0], 13'b0_0111_1111_1111); end
        total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL parity_idle_main: got %0d frames required 0", rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        rx_t r[2];
        logic [7:0] want;
        logic [21:0] want_line;
        load(8'hA3);
        fork
            load(8'h3C);
            record(22);
        join
        want_line = {2'b11, frame8(8'h3C), frame8(8'hA3)};
        total++; if (rec_m[21:0] !== want_line) begin bad++; $display("FAIL b2b_line: got %b required %b", rec_m[21:0], want_line); end
        wait_frames(2);
        for (int i = 0; i < 2 && rx_q.size() > 0; i++) begin
            r[i] = rx_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (r[i].data !== want || r[i].stop !== 1'b1) begin bad++; $display("FAIL b2b_data: got %h stop %b required %h stop 1", r[i].data, r[i].stop, want); end
        end
        total++; if (r[1].start - r[0].start !== 10) begin bad++; $display("FAIL b2b_gap: got %0d ticks between starts required 10", r[1].start - r[0].start); end
    endtask

    task automatic test_overflow();
        rx_t r;
        logic [7:0] want;
        load(8'h11);
        load(8'h22);
        @(negedge clk);
        m_if.tx_data = 8'hFF;
        m_if.xmit_go = 1'b1;
        @(posedge clk); #1;
        m_if.xmit_go = 1'b0;
        total++; if (m_if.tx_empty !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b required 0", m_if.tx_empty); end
        wait_frames(2);
        repeat (15) wait_tick();
        total++; if (rx_q.size() !== 2) begin bad++; $display("FAIL ovf_count: got %0d frames required 2", rx_q.size()); end
        while (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (r.data !== want) begin bad++; $display("FAIL ovf_data: got %h required %h", r.data, want); end
        end
    endtask

    task automatic test_reset_mid_frame();
        rx_t r;
        logic [7:0] want;
        load(8'h5A);
        repeat (5) wait_tick();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (m_out !== 1'b1) begin bad++; $display("FAIL midrst_tx_out: got %b required 1", m_out); end
        total++; if (m_if.tx_empty !== 1'b1) begin bad++; $display("FAIL midrst_tx_empty: got %b required 1", m_if.tx_empty); end
        total++; if (m_if.tx_busy !== 1'b0) begin bad++; $display("FAIL midrst_tx_busy: got %b required 0", m_if.tx_busy); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        load(8'hC3);
        record(12);
        total++; if (rec_m[11:0] !== {2'b11, frame8(8'hC3)}) begin bad++; $display("FAIL midrst_line: got %b required %b", rec_m[11:0], {2'b11, frame8(8'hC3)}); end
        wait_frames(1);
        total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL midrst_count: got %0d frames required 1", rx_q.size()); end
        while (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (r.data !== want) begin bad++; $display("FAIL midrst_data: got %h required %h", r.data, want); end
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        rx_t r;
        logic [7:0] want;
        logic [14:0] seen;
        load(8'h96);
        load(8'h69);
        repeat (3) wait_tick();
        @(negedge clk);
        brk = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wait_tick();
            seen[i] = m_out;
        end
        total++; if (seen !== 15'h0000) begin bad++; $display("FAIL break_low: got %b required all 0", seen); end
        @(negedge clk);
        brk = 1'b0;
        @(posedge clk); #1;
        total++; if (m_out !== 1'b1) begin bad++; $display("FAIL break_release_line: got %b required 1", m_out); end
        total++; if (m_if.tx_busy !== 1'b0) begin bad++; $display("FAIL break_release_busy: got %b required 0", m_if.tx_busy); end
        total++; if (m_if.tx_empty !== 1'b0) begin bad++; $display("FAIL break_hold_kept: got %b required 0", m_if.tx_empty); end
        void'(exp_q.pop_front());
        wait_frames(1);
        while (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++; if (r.data !== want || r.stop !== 1'b1) begin bad++; $display("FAIL break_data: got %h stop %b required %h stop 1", r.data, r.stop, want); end
        end
    endtask
`endif

    initial begin
        m_if.tx_data = 8'h00; m_if.xmit_go = 1'b0;
        e_if.tx_data = 8'h00; e_if.xmit_go = 1'b0;
        o_if.tx_data = 8'h00; o_if.xmit_go = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
